// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive control path: FSM states,
// line-status bit positions in the RX push word, and word-length decoding.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    CHECK  = 3'd5
  } rx_state_t;

  localparam int RX_BRK = 10;
  localparam int RX_FE  = 9;
  localparam int RX_PE  = 8;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  typedef struct packed {
    logic [1:0] wls;
    logic       pen;
    logic       eps;
    logic       sp;
  } rx_cfg_t;

  function automatic logic [2:0] last_data_bit(input logic [1:0] wls);
    return 3'd4 + {1'b0, wls};
  endfunction

  function automatic logic [7:0] data_mask(input logic [1:0] wls);
    return 8'hFF >> (WLS_8 - wls);
  endfunction

  // Stick parity forces the bit to ~eps; otherwise even/odd over the N data bits.
  function automatic logic parity_error(input logic [7:0] data,
                                        input logic [1:0] wls,
                                        input logic       received,
                                        input logic       eps,
                                        input logic       sp);
    logic expected;
    if (sp) begin
      expected = ~eps;
    end else begin
      expected = (^(data & data_mask(wls))) ^ ~eps;
    end
    return received != expected;
  endfunction

endpackage

// File: rtl/uart_rx_sample_timer.sv
// Per-bit oversampling counter for the UART receiver: produces the three
// majority-vote strobes, the post-vote shift pulse and the end-of-bit wrap.
module uart_rx_sample_timer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int VOTE_TICK  = 7
) (
  input  logic pclk,
  input  logic presetn,
  input  logic baud_tick,
  input  logic active,
  input  logic load,
  output logic vote_en,
  output logic shift_pulse,
  output logic bit_done
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] LOAD_VAL   = CW'(2);
  localparam logic [CW-1:0] VOTE_FIRST = CW'(VOTE_TICK);
  localparam logic [CW-1:0] VOTE_LAST  = CW'(VOTE_TICK + 2);
  localparam logic [CW-1:0] LAST_TICK  = CW'(OVERSAMPLE - 1);

  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic          shift_pulse_q, shift_pulse_d;
  logic          at_vote;

  assign at_vote = (tick_cnt_q >= VOTE_FIRST) && (tick_cnt_q <= VOTE_LAST);

  // Load value of 2 absorbs the two ticks the vote register needs to see the falling edge.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (load) begin
      tick_cnt_d = LOAD_VAL;
    end else if (!active) begin
      tick_cnt_d = '0;
    end else if (baud_tick) begin
      tick_cnt_d = (tick_cnt_q == LAST_TICK) ? '0 : tick_cnt_q + CW'(1);
    end
  end

  always_comb begin
    shift_pulse_d = baud_tick && active && !load && (tick_cnt_q == VOTE_LAST);
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tick_cnt_q    <= '0;
      shift_pulse_q <= 1'b0;
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      shift_pulse_q <= shift_pulse_d;
    end
  end

  assign vote_en     = baud_tick && active && at_vote;
  assign shift_pulse = shift_pulse_q;
  assign bit_done    = baud_tick && active && (tick_cnt_q == LAST_TICK);

endmodule

// File: rtl/uart_receiver_ctrl.sv
// UART receive control FSM: frames start/data/parity/stop bits from the 16x
// baud tick, strobes the vote/shift datapath and pushes {status, data} to the RX FIFO.
module uart_receiver_ctrl
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int VOTE_TICK  = 7
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        baud_tick,
  input  logic        rx_en,
  input  logic [1:0]  wls,
  input  logic        pen,
  input  logic        eps,
  input  logic        sp,
  input  logic        rx_data,
  input  logic [7:0]  rsr_data,
  input  logic        received_parity,
  input  logic        frame_error,
  input  logic        all_zero,
  output logic        voting_shift_en,
  output logic        receive_shift_en,
  output logic        error_check,
  output logic        rx_push,
  output logic [10:0] rx_push_data,
  output logic        rx_busy
);

  rx_state_t   state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  rx_cfg_t     cfg_q, cfg_d;
  logic        rx_push_q, rx_push_d;
  logic [10:0] rx_push_data_q, rx_push_data_d;

  logic        in_frame;
  logic        start_det;
  logic        false_start;
  logic        vote_en;
  logic        shift_pulse;
  logic        bit_done;
  logic        cap_brk;
  logic        cap_pe;
  logic [7:0]  cap_data;

  assign in_frame    = (state_q == START) || (state_q == DATA) ||
                       (state_q == PARITY) || (state_q == STOP);
  assign start_det   = (state_q == IDLE) && rx_en && !rx_data;
  assign false_start = (state_q == START) && rx_data;

  uart_rx_sample_timer #(
    .OVERSAMPLE (OVERSAMPLE),
    .VOTE_TICK  (VOTE_TICK)
  ) u_timer (
    .pclk        (pclk),
    .presetn     (presetn),
    .baud_tick   (baud_tick),
    .active      (in_frame && rx_en),
    .load        (start_det),
    .vote_en     (vote_en),
    .shift_pulse (shift_pulse),
    .bit_done    (bit_done)
  );

  // IDLE votes every tick to catch the start edge; in-frame only the three mid-bit ticks vote.
  assign voting_shift_en  = presetn && rx_en && ((state_q == IDLE) ? baud_tick : vote_en);
  assign receive_shift_en = shift_pulse && in_frame && rx_en && !false_start;
  assign error_check      = (state_q == CHECK);
  assign rx_busy          = (state_q != IDLE);

  assign cap_brk  = all_zero;
  assign cap_pe   = cfg_q.pen &&
                    parity_error(rsr_data, cfg_q.wls, received_parity, cfg_q.eps, cfg_q.sp);
  assign cap_data = cap_brk ? 8'h00 : rsr_data;

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    cfg_d          = cfg_q;
    rx_push_d      = 1'b0;
    rx_push_data_d = rx_push_data_q;
    if (!rx_en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!rx_data) begin
            state_d   = START;
            bit_cnt_d = 3'd0;
            cfg_d.wls = wls;
            cfg_d.pen = pen;
            cfg_d.eps = eps;
            cfg_d.sp  = sp;
          end
        end
        START: begin
          if (shift_pulse && rx_data) begin
            state_d = IDLE;
          end else if (bit_done) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_cnt_q == last_data_bit(cfg_q.wls)) begin
              state_d = cfg_q.pen ? PARITY : STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        PARITY: begin
          if (bit_done) begin
            state_d = STOP;
          end
        end
        // Only the first stop bit is sampled; leaving early lets the next start be seen.
        STOP: begin
          if (receive_shift_en) begin
            state_d = CHECK;
          end
        end
        CHECK: begin
          state_d                = IDLE;
          rx_push_d              = 1'b1;
          rx_push_data_d         = '0;
          rx_push_data_d[RX_BRK] = cap_brk;
          rx_push_data_d[RX_FE]  = frame_error;
          rx_push_data_d[RX_PE]  = cap_pe;
          rx_push_data_d[7:0]    = cap_data;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q        <= IDLE;
      bit_cnt_q      <= 3'd0;
      cfg_q          <= '0;
      rx_push_q      <= 1'b0;
      rx_push_data_q <= '0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      cfg_q          <= cfg_d;
      rx_push_q      <= rx_push_d;
      rx_push_data_q <= rx_push_data_d;
    end
  end

  assign rx_push      = rx_push_q;
  assign rx_push_data = rx_push_data_q;

endmodule

// File: tb/tb_uart_receiver_ctrl.sv
// Directed bench for uart_receiver_ctrl with a behavioural vote/shift datapath
// driven from a serial line; expected push words are hand-computed constants.
module tb_uart_receiver_ctrl;

  logic        pclk = 1'b0;
  logic        presetn = 1'b1;
  logic        baud_tick = 1'b0;
  logic        rx_en = 1'b0;
  logic [1:0]  wls = 2'b11;
  logic        pen = 1'b0;
  logic        eps = 1'b0;
  logic        sp = 1'b0;
  logic        rx_data;
  logic [7:0]  rsr_data;
  logic        received_parity;
  logic        frame_error;
  logic        all_zero;
  logic        voting_shift_en;
  logic        receive_shift_en;
  logic        error_check;
  logic        rx_push;
  logic [10:0] rx_push_data;
  logic        rx_busy;

  logic        line = 1'b1;
  int          m_n = 8;
  logic        m_pen = 1'b0;
  logic [1:0]  div = 2'd0;

  int tests = 0;
  int fails = 0;

  uart_receiver_ctrl dut (
    .pclk             (pclk),
    .presetn          (presetn),
    .baud_tick        (baud_tick),
    .rx_en            (rx_en),
    .wls              (wls),
    .pen              (pen),
    .eps              (eps),
    .sp               (sp),
    .rx_data          (rx_data),
    .rsr_data         (rsr_data),
    .received_parity  (received_parity),
    .frame_error      (frame_error),
    .all_zero         (all_zero),
    .voting_shift_en  (voting_shift_en),
    .receive_shift_en (receive_shift_en),
    .error_check      (error_check),
    .rx_push          (rx_push),
    .rx_push_data     (rx_push_data),
    .rx_busy          (rx_busy)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) begin
    div       <= div + 2'd1;
    baud_tick <= (div == 2'd3);
  end

  // Behavioural datapath: 3-sample majority vote and LSB-first character assembly.
  logic [2:0] vote_q;
  logic [7:0] rsr_q;
  logic       par_q, fe_q, az_q;
  int         shift_idx;

  assign rx_data         = (vote_q[0] & vote_q[1]) | (vote_q[1] & vote_q[2]) | (vote_q[0] & vote_q[2]);
  assign rsr_data        = rsr_q;
  assign received_parity = par_q;
  assign frame_error     = fe_q;
  assign all_zero        = az_q;

  always @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      vote_q    <= 3'b111;
      rsr_q     <= 8'h00;
      par_q     <= 1'b0;
      fe_q      <= 1'b0;
      az_q      <= 1'b0;
      shift_idx <= 0;
    end else begin
      if (voting_shift_en) vote_q <= {vote_q[1:0], line};
      if (!rx_busy) begin
        shift_idx <= 0;
      end else if (receive_shift_en) begin
        shift_idx <= shift_idx + 1;
        if (shift_idx == 0) begin
          rsr_q <= 8'h00;
          par_q <= 1'b0;
        end else if (shift_idx <= m_n) begin
          rsr_q[shift_idx-1] <= rx_data;
        end else if (m_pen && shift_idx == m_n + 1) begin
          par_q <= rx_data;
        end else begin
          fe_q <= !rx_data;
          az_q <= (rsr_q == 8'h00) && !rx_data && !(m_pen && par_q);
        end
      end
    end
  end

  // Observation bookkeeping sampled on the falling edge.
  int         cyc = 0;
  int         total_shifts = 0;
  int         frame_shifts = 0;
  int         push_shifts = 0;
  int         last_shift_cyc = 0;
  int         push_lat = 0;
  int         push_total = 0;
  int         votes_since = 0;
  int         vote_errs = 0;
  int         busy_rises = 0;
  logic       busy_prev = 1'b0;
  logic [10:0] push_log[$];

  always @(negedge pclk) begin
    cyc       <= cyc + 1;
    busy_prev <= rx_busy;
    if (rx_busy && !busy_prev) busy_rises <= busy_rises + 1;
    if (receive_shift_en) begin
      total_shifts   <= total_shifts + 1;
      last_shift_cyc <= cyc;
      if (votes_since != 3) vote_errs <= vote_errs + 1;
    end
    if (!rx_busy) frame_shifts <= 0;
    else if (receive_shift_en) frame_shifts <= frame_shifts + 1;
    if (!rx_busy || receive_shift_en) votes_since <= 0;
    else if (voting_shift_en) votes_since <= votes_since + 1;
    if (rx_push) begin
      push_total  <= push_total + 1;
      push_log.push_back(rx_push_data);
      push_lat    <= cyc - last_shift_cyc;
      push_shifts <= frame_shifts;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  int push_idx = 0;

  task automatic checkPush(input string tag, input logic [10:0] exp);
    logic [31:0] obs;
    obs = (push_log.size() > push_idx) ? 32'(push_log[push_idx]) : 32'hDEAD;
    push_idx++;
    checkOutput(tag, obs, 32'(exp));
  endtask

  task automatic waitTicks(input int n);
    repeat (n) begin
      do begin
        @(posedge pclk);
        #1;
      end while (baud_tick !== 1'b1);
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [15:0] bits, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      line = bits[i];
      waitTicks(16);
    end
  endtask

  task automatic setConfig(input logic [1:0] w, input logic p, input logic e, input logic s);
    wls   = w;
    pen   = p;
    eps   = e;
    sp    = s;
    m_n   = 5 + int'(w);
    m_pen = p;
  endtask

  function automatic logic [15:0] buildFrame(input logic [7:0] d, input int n,
                                             input logic use_par, input logic par,
                                             input logic stop);
    logic [15:0] f;
    f = 16'hFFFF;
    f[0] = 1'b0;
    for (int i = 0; i < n; i++) f[1+i] = d[i];
    if (use_par) f[1+n] = par;
    f[1+n+int'(use_par)] = stop;
    return f;
  endfunction

  task automatic sendFrame(input logic [7:0] d, input int n, input logic use_par,
                           input logic par, input logic stop);
    applyStimulus(buildFrame(d, n, use_par, par, stop), 0, n + 1 + int'(use_par));
  endtask

  int p0, s0, b0;
  logic [15:0] fbits;

  initial begin
    #2 presetn = 1'b0;
    repeat (5) @(posedge pclk);
    #1;
    checkOutput("reset_outputs",
                32'({voting_shift_en, receive_shift_en, error_check, rx_push, rx_busy, rx_push_data}), 32'h0);
    presetn = 1'b1;
    @(posedge pclk);
    #1;
    rx_en = 1'b1;
    waitTicks(20);

    // 8N1, 0xA5
    setConfig(2'b11, 1'b0, 1'b0, 1'b0);
    p0 = push_total;
    sendFrame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    waitTicks(4);
    checkOutput("8n1_push_count", 32'(push_total - p0), 32'd1);
    checkPush("8n1_data", 11'h0A5);
    checkOutput("8n1_shift_count", 32'(push_shifts), 32'd10);
    checkOutput("8n1_votes_per_shift", 32'(vote_errs), 32'd0);
    checkOutput("8n1_push_latency", 32'(push_lat), 32'd2);

    // 7E1, 0x35: even parity bit should be 0
    setConfig(2'b10, 1'b1, 1'b1, 1'b0);
    sendFrame(8'h35, 7, 1'b1, 1'b1, 1'b1);
    waitTicks(4);
    checkPush("7e1_bad_parity", 11'h135);
    fbits = buildFrame(8'h35, 7, 1'b1, 1'b0, 1'b1);
    applyStimulus(fbits, 0, 1);
    eps = 1'b0;
    applyStimulus(fbits, 2, 9);
    eps = 1'b1;
    waitTicks(4);
    checkPush("7e1_good_parity_eps_held", 11'h035);

    // 5-bit stick parity with eps=0: parity bit must be 1
    setConfig(2'b00, 1'b1, 1'b0, 1'b1);
    sendFrame(8'h1F, 5, 1'b1, 1'b1, 1'b1);
    waitTicks(4);
    checkPush("stick_good", 11'h01F);
    sendFrame(8'h1F, 5, 1'b1, 1'b0, 1'b1);
    waitTicks(4);
    checkPush("stick_bad", 11'h11F);

    // 8N1 with the stop bit low
    setConfig(2'b11, 1'b0, 1'b0, 1'b0);
    p0 = push_total;
    sendFrame(8'h3C, 8, 1'b0, 1'b0, 1'b0);
    line = 1'b1;
    waitTicks(40);
    checkOutput("stop_low_push_count", 32'(push_total - p0), 32'd1);
    checkPush("stop_low_data", 11'h23C);

    // Line low for two full frames, then rx_en drop aborts the re-framed third
    p0 = push_total;
    applyStimulus(16'h0000, 0, 15);
    applyStimulus(16'h0000, 0, 3);
    line = 1'b1;
    waitTicks(4);
    checkOutput("break_refr_busy", 32'(rx_busy), 32'd1);
    rx_en = 1'b0;
    @(posedge pclk);
    #1;
    checkOutput("abort_busy", 32'(rx_busy), 32'd0);
    @(posedge pclk);
    #1;
    rx_en = 1'b1;
    waitTicks(40);
    checkOutput("break_push_count", 32'(push_total - p0), 32'd2);
    checkPush("break_data_1", 11'h600);
    checkPush("break_data_2", 11'h600);

    // 4-tick glitch: false start
    p0 = push_total;
    s0 = total_shifts;
    b0 = busy_rises;
    line = 1'b0;
    waitTicks(4);
    line = 1'b1;
    waitTicks(32);
    checkOutput("glitch_start_entered", 32'(busy_rises - b0), 32'd1);
    checkOutput("glitch_no_shift", 32'(total_shifts - s0), 32'd0);
    checkOutput("glitch_no_push", 32'(push_total - p0), 32'd0);
    checkOutput("glitch_idle", 32'(rx_busy), 32'd0);

    // Reset after the third data bit
    p0 = push_total;
    applyStimulus(buildFrame(8'h5A, 8, 1'b0, 1'b0, 1'b1), 0, 3);
    checkOutput("rstmid_busy_before", 32'(rx_busy), 32'd1);
    presetn = 1'b0;
    #1;
    checkOutput("rstmid_outputs",
                32'({voting_shift_en, receive_shift_en, error_check, rx_push, rx_busy, rx_push_data}), 32'h0);
    line = 1'b1;
    repeat (4) @(posedge pclk);
    #1;
    presetn = 1'b1;
    waitTicks(32);
    checkOutput("rstmid_no_push", 32'(push_total - p0), 32'd0);

    // Back-to-back frames
    p0 = push_total;
    sendFrame(8'h55, 8, 1'b0, 1'b0, 1'b1);
    sendFrame(8'hAA, 8, 1'b0, 1'b0, 1'b1);
    waitTicks(4);
    checkOutput("b2b_push_count", 32'(push_total - p0), 32'd2);
    checkPush("b2b_first", 11'h055);
    checkPush("b2b_second", 11'h0AA);
    checkOutput("b2b_latency", 32'(push_lat), 32'd2);

    checkOutput("vote_alignment_all", 32'(vote_errs), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_receiver_ctrl.md
Name: uart_receiver_ctrl

Overview:
Control FSM directly upstream of the UART receiver shift/voting datapath. Works from the 16x oversampling baud tick and tracks start, data, parity and stop bit positions. Drives the datapath's voting_shift_en, receive_shift_en and error_check strobes, then packs the received character and its line-status bits into one push toward the RX FIFO/RBR.

Parameters:
OVERSAMPLE, 16, baud ticks per bit (power of two, at least 8)
VOTE_TICK, 7, tick index of the first of three majority-vote samples in each bit

Ports:
pclk  input  1  UART clock
presetn  input  1  active-low reset, asynchronous assert
baud_tick  input  1  one-pclk pulse at 16x baud rate
rx_en  input  1  receiver enable
wls  input  2  word length select: 00=5, 01=6, 10=7, 11=8 data bits
pen  input  1  parity enable
eps  input  1  even parity select
sp  input  1  stick parity
rx_data  input  1  majority-voted line value from the datapath
rsr_data  input  8  assembled character from the datapath, right-justified
received_parity  input  1  parity bit captured by the datapath
frame_error  input  1  datapath framing flag, valid while error_check=1
all_zero  input  1  datapath shift register all zeros
voting_shift_en  output  1  shift one raw line sample into the vote register
receive_shift_en  output  1  shift rx_data into the receive shift register
error_check  output  1  qualifies frame_error
rx_push  output  1  one-cycle write strobe to the RX FIFO
rx_push_data  output  11  {break, frame_err, parity_err, data[7:0]}
rx_busy  output  1  high in any state except IDLE

Behaviour:
- Reset: state=IDLE, tick_cnt=0, bit_cnt=0. Every output is 0, including rx_push_data=0. Reset mid-frame discards the frame with no push.
- tick_cnt advances only on baud_tick and wraps OVERSAMPLE-1 -> 0. bit_cnt is 3 bits.
- voting_shift_en = baud_tick, combinationally, in IDLE. In the other frame states it equals baud_tick only when tick_cnt is VOTE_TICK, VOTE_TICK+1 or VOTE_TICK+2.
- receive_shift_en is a registered one-cycle pulse in the pclk cycle after the baud_tick where tick_cnt=VOTE_TICK+2. This places it after the third vote has landed, so rx_data is settled.
- Data bit count N = 5 + wls. Frame length F = 1 + N + pen + 1.
- States:
  - IDLE: when rx_en=1 and rx_data=0, go to START and load tick_cnt=2 to compensate for the vote-register delay. With rx_en=0, stay in IDLE and pulse no strobes.
  - START: at the vote point, if rx_data=1 it is a false start; return to IDLE with no shift and no push. If rx_data=0, pulse receive_shift_en, set bit_cnt=0 and go to DATA at the tick wrap.
  - DATA: pulse one shift per bit and increment bit_cnt. After bit N-1, go to PARITY if pen=1, else to STOP.
  - PARITY: one shift, then STOP.
  - STOP: one shift for the first stop bit only; a second stop bit is never checked. The cycle after that shift goes to CHECK.
  - CHECK: lasts one pclk with error_check=1. Capture the following:
    - frame_err = frame_error
    - break = all_zero
    - parity_err, only when pen=1:
      - sp=1: received_parity != ~eps
      - sp=0, eps=1: received_parity != ^rsr_data[N-1:0]
      - sp=0, eps=0: received_parity != ~^rsr_data[N-1:0]
    - parity_err = 0 when pen=0.
    - When break=1, force data to 0x00.
  - Next cycle: rx_push=1 for one pclk, rx_push_data holds the captured values, go to IDLE. rx_push_data holds its value until the next push.
- Latency: rx_push rises exactly 2 pclk after the stop-bit receive_shift_en.
- A new start bit can be detected in the first IDLE cycle after the push. Back-to-back frames must be received without loss.
- rx_en falling mid-frame aborts to IDLE at the next pclk with no push.
- rx_push is never back-pressured; overrun is handled downstream.
- wls, pen, eps and sp are sampled at start detection and held for the rest of the frame; changes mid-frame are ignored.

Decomposition:
- uart_pkg holds:
  - rx_state_t enum: IDLE, START, DATA, PARITY, STOP, CHECK
  - bit positions RX_BRK=10, RX_FE=9, RX_PE=8
  - WLS encodings
- One sub-module, uart_rx_sample_timer. It contains tick_cnt and the vote/shift strobe generation. Inputs: baud_tick, active, load. Outputs: vote_en, shift_pulse, bit_done.

Test Plan:
- 8N1 (wls=11, pen=0), 0xA5 driven on the line -> exactly 10 receive_shift_en pulses, each preceded by 3 voting pulses; one rx_push with rx_push_data=0x0A5, 2 pclk after the last shift.
- 7E1 (wls=10, pen=1, eps=1), data 0x35 sent with wrong parity bit 1 -> rx_push_data=0x135 (parity_err=1); the same frame with parity 0 -> 0x035.
- 5-bit stick parity (wls=00, pen=1, sp=1, eps=0), data 0x1F with parity bit 1 -> rx_push_data=0x01F; parity bit 0 -> 0x11F.
- 8N1 with stop bit driven low, data 0x3C -> rx_push_data=0x23C. Line held low for 2 full frames -> rx_push_data=0x600 (break and frame_err set).
- A 4-tick low glitch in IDLE -> START is entered, rx_data=1 at the vote point, return to IDLE with zero receive_shift_en pulses and no rx_push.
- presetn asserted after the 3rd data bit of a frame -> all outputs 0 immediately and no push. Two back-to-back 0x55 and 0xAA frames after reset -> two pushes, 0x055 then 0x0AA.
